// File: rtl/mux4_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter_if
// Description : Request/grant bundle between requesters (master) and the
//               round-robin mux arbiter (slave). lock exists with ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
`ifdef ARB_LOCK_EN
    logic       lock;

    modport master (
        output req,
        output lock,
        input  gnt,
        input  sel,
        input  busy
    );

    modport slave (
        input  req,
        input  lock,
        output gnt,
        output sel,
        output busy
    );
`else
    modport master (
        output req,
        input  gnt,
        input  sel,
        input  busy
    );

    modport slave (
        input  req,
        output gnt,
        output sel,
        output busy
    );
`endif
endinterface : mux4_rr_arbiter_if
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter
// Description : Round-robin scheduler driving the select of a 4:1 mux, with a
//               hold timer bounding each owner's tenure. Optional macro
//               ARB_LOCK_EN adds a lock input that suppresses timeout preemption.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mux4_rr_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

    state_t           state_q;
    logic [3:0]       gnt_q;
    logic [1:0]       sel_q;
    logic             busy_q;
    logic [1:0]       ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0]       others_d;
    logic [1:0]       next_ptr_d;
    logic [1:0]       next_own_d;
    logic             owner_req_d;
    logic             timeout_d;
    logic             lock_d;

    // First set bit of r, searching cyclically upward from start.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        pick = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) begin
                pick = idx;
            end
        end
    endfunction

`ifdef ARB_LOCK_EN
    assign lock_d = bus.lock;
`else
    assign lock_d = 1'b0;
`endif

    assign others_d    = bus.req & ~gnt_q;
    assign owner_req_d = bus.req[sel_q];
    assign next_ptr_d  = pick(bus.req, ptr_q);
    assign next_own_d  = pick(others_d, sel_q + 2'd1);
    assign timeout_d   = (cnt_q == CNT_MAX) && !lock_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= 4'b0001 << next_ptr_d;
                        sel_q   <= next_ptr_d;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!owner_req_d) begin
                        ptr_q <= sel_q + 2'd1;
                        cnt_q <= '0;
                        if (|others_d) begin
                            gnt_q <= 4'b0001 << next_own_d;
                            sel_q <= next_own_d;
                        end else begin
                            // sel keeps the last owner so the mux output stays stable.
                            state_q <= ST_IDLE;
                            gnt_q   <= 4'b0000;
                            busy_q  <= 1'b0;
                        end
                    end else if (timeout_d && (|others_d)) begin
                        ptr_q <= sel_q + 2'd1;
                        cnt_q <= '0;
                        gnt_q <= 4'b0001 << next_own_d;
                        sel_q <= next_own_d;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= 4'b0000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;

endmodule : mux4_rr_arbiter
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_rr_arbiter
// Description : Directed self-checking bench for mux4_rr_arbiter (HOLD_MAX=4,
//               plus a HOLD_MAX=1 instance). Lock checks need ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

    logic clk;
    logic rst_n;
    int   n_err;
    int   n_chk;

    mux4_rr_arbiter_if bus ();
    mux4_rr_arbiter_if bus1 ();

    mux4_rr_arbiter #(.HOLD_MAX(4), .CNT_W(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    mux4_rr_arbiter #(.HOLD_MAX(1), .CNT_W(4)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        rst_n = 1'b0;
        bus.req  = 4'b1111;
        bus1.req = 4'b0000;
`ifdef ARB_LOCK_EN
        bus.lock  = 1'b0;
        bus1.lock = 1'b0;
`endif
        // Reset values before any clock edge.
        #2;
        check("rst_gnt",  32'(bus.gnt),  32'h0);
        check("rst_sel",  32'(bus.sel),  32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;

        // Full contention: each owner holds exactly 4 cycles, rotating 0..3,0.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("rr_gnt", 32'(bus.gnt), 32'(4'b0001 << ((i / 4) % 4)));
            check("rr_sel", 32'(bus.sel), 32'((i / 4) % 4));
            check("rr_busy", 32'(bus.busy), 32'h1);
        end

        bus.req = 4'b0000;
        tick();
        check("idle_gnt",  32'(bus.gnt),  32'h0);
        check("idle_busy", 32'(bus.busy), 32'h0);
        check("idle_sel",  32'(bus.sel),  32'h0);

        // Single requester c, then release; sel holds 2 afterwards.
        bus.req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("c_gnt",  32'(bus.gnt),  32'h4);
            check("c_sel",  32'(bus.sel),  32'h2);
            check("c_busy", 32'(bus.busy), 32'h1);
        end
        bus.req = 4'b0000;
        tick();
        check("rel_gnt",  32'(bus.gnt),  32'h0);
        check("rel_busy", 32'(bus.busy), 32'h0);
        check("rel_sel",  32'(bus.sel),  32'h2);

        // ptr now 3: search wraps to 0. Owner 0 drops after 2 cycles.
        bus.req = 4'b0011;
        tick();
        check("wrap_gnt", 32'(bus.gnt), 32'h1);
        tick();
        check("wrap_gnt2", 32'(bus.gnt), 32'h1);
        bus.req = 4'b0010;
        tick();
        check("handoff_gnt",  32'(bus.gnt),  32'h2);
        check("handoff_busy", 32'(bus.busy), 32'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("solo_gnt", 32'(bus.gnt), 32'h2);
        end
        bus.req = 4'b0000;
        tick();
        check("solo_rel", 32'(bus.gnt), 32'h0);

        // Async reset mid-grant, then arbitration restarts from index 0.
        bus.req = 4'b0100;
        tick();
        check("pre_rst_gnt", 32'(bus.gnt), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_gnt",  32'(bus.gnt),  32'h0);
        check("async_busy", 32'(bus.busy), 32'h0);
        check("async_sel",  32'(bus.sel),  32'h0);
        rst_n = 1'b1;
        bus.req = 4'b1001;
        tick();
        check("restart_gnt", 32'(bus.gnt), 32'h1);

`ifdef ARB_LOCK_EN
        bus.req  = 4'b1111;
        bus.lock = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("lock_gnt", 32'(bus.gnt), 32'h1);
        end
        bus.lock = 1'b0;
        tick();
        check("unlock_gnt", 32'(bus.gnt), 32'h2);
`endif

        // HOLD_MAX=1: owner rotates every cycle under contention.
        bus1.req = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("h1_gnt", 32'(bus1.gnt), (i % 2 == 0) ? 32'h1 : 32'h4);
            check("h1_sel", 32'(bus1.sel), (i % 2 == 0) ? 32'h0 : 32'h2);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_mux4_rr_arbiter
`default_nettype wire
